fpu_issue_ctrl: RTL and testbench

//  Issue/writeback controller upstream of the private FPU (fpu_private). Accepts one FP op per cycle from
//  the core over valid/ready and drives the FPU enable/operand/cmd inputs. Reserves writeback slots so

---
 rtl/fpu_issue_ctrl.sv | 228 ++++++++++++++++++++++
 tb/tb_fpu_issue_ctrl.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_issue_ctrl.sv
// fpu_issue_ctrl
//   Issue/writeback controller in front of the private FPU. Accepts one FP op
//   per cycle over valid/ready, drives the FPU command/operand inputs, reserves
//   writeback slots so fixed-latency results never collide, serialises
//   iterative div/sqrt and returns each result with its destination tag.
//   Sticky accumulated fflags and a sticky protocol error flag are kept.
// Ports
//   clk_i, rst_ni                        clock, async active-low reset
//   req_valid_i/req_ready_o              core request handshake
//   req_op/rm/prec/a/b/c/tag_i           request command, operands, dest tag
//   fpu_en_o, fpu_op/rm/prec/a/b/c_o     one-cycle FPU issue + pass-through
//   fpu_valid_i/result_i/flags_i         FPU result return
//   divsqrt_busy_i                       div/sqrt unit cannot start
//   wb_valid/tag/result/flags_o          registered writeback
//   fflags_clr_i, fflags_o               sticky flag accumulator and clear
//   err_o                                sticky protocol error
module fpu_issue_ctrl #(
  parameter int unsigned C_OP     = 32,
  parameter int unsigned C_CMD    = 4,
  parameter int unsigned C_RM     = 3,
  parameter int unsigned C_PC     = 5,
  parameter int unsigned C_FFLAG  = 5,
  parameter int unsigned TAG_W    = 5,
  parameter int unsigned LAT_CORE = 2,
  parameter int unsigned LAT_FMA  = 3
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               req_valid_i,
  output logic               req_ready_o,
  input  logic [C_CMD-1:0]   req_op_i,
  input  logic [C_RM-1:0]    req_rm_i,
  input  logic [C_PC-1:0]    req_prec_i,
  input  logic [C_OP-1:0]    req_a_i,
  input  logic [C_OP-1:0]    req_b_i,
  input  logic [C_OP-1:0]    req_c_i,
  input  logic [TAG_W-1:0]   req_tag_i,
  output logic               fpu_en_o,
  output logic [C_CMD-1:0]   fpu_op_o,
  output logic [C_RM-1:0]    fpu_rm_o,
  output logic [C_PC-1:0]    fpu_prec_o,
  output logic [C_OP-1:0]    fpu_a_o,
  output logic [C_OP-1:0]    fpu_b_o,
  output logic [C_OP-1:0]    fpu_c_o,
  input  logic               fpu_valid_i,
  input  logic [C_OP-1:0]    fpu_result_i,
  input  logic [C_FFLAG-1:0] fpu_flags_i,
  input  logic               divsqrt_busy_i,
  output logic               wb_valid_o,
  output logic [TAG_W-1:0]   wb_tag_o,
  output logic [C_OP-1:0]    wb_result_o,
  output logic [C_FFLAG-1:0] wb_flags_o,
  input  logic               fflags_clr_i,
  output logic [C_FFLAG-1:0] fflags_o,
  output logic               err_o
);

  localparam logic [C_CMD-1:0] CMD_ADD    = C_CMD'(0);
  localparam logic [C_CMD-1:0] CMD_SUB    = C_CMD'(1);
  localparam logic [C_CMD-1:0] CMD_MUL    = C_CMD'(2);
  localparam logic [C_CMD-1:0] CMD_DIV    = C_CMD'(3);
  localparam logic [C_CMD-1:0] CMD_I2F    = C_CMD'(4);
  localparam logic [C_CMD-1:0] CMD_F2I    = C_CMD'(5);
  localparam logic [C_CMD-1:0] CMD_SQRT   = C_CMD'(6);
  localparam logic [C_CMD-1:0] CMD_FMADD  = C_CMD'(8);
  localparam logic [C_CMD-1:0] CMD_FMSUB  = C_CMD'(9);
  localparam logic [C_CMD-1:0] CMD_FNMADD = C_CMD'(10);
  localparam logic [C_CMD-1:0] CMD_FNMSUB = C_CMD'(11);

  localparam logic [C_FFLAG-1:0] FLAG_NV = {1'b1, {(C_FFLAG-1){1'b0}}};

  typedef enum logic {S_IDLE, S_DIVSQRT} state_e;

  state_e             state_q, state_d;
  // Entry j is the result due j cycles after the current one (j=0: now).
  logic [LAT_FMA-1:0] due_v_q, due_v_d;
  logic [LAT_FMA-1:0] due_ill_q, due_ill_d;
  logic [TAG_W-1:0]   due_tag_q [LAT_FMA];
  logic [TAG_W-1:0]   due_tag_d [LAT_FMA];
  logic [TAG_W-1:0]   ds_tag_q, ds_tag_d;

  logic               wb_valid_q, wb_valid_d;
  logic [TAG_W-1:0]   wb_tag_q, wb_tag_d;
  logic [C_OP-1:0]    wb_result_q, wb_result_d;
  logic [C_FFLAG-1:0] wb_flags_q, wb_flags_d;
  logic [C_FFLAG-1:0] fflags_q, fflags_d;
  logic               err_q, err_d;

  logic               is_core, is_fma, is_ds, known, accept;
  logic [LAT_FMA:0]   busy_vec;
  logic [LAT_FMA-1:0] ins_oh;

  assign fpu_op_o   = req_op_i;
  assign fpu_rm_o   = req_rm_i;
  assign fpu_prec_o = req_prec_i;
  assign fpu_a_o    = req_a_i;
  assign fpu_b_o    = req_b_i;
  assign fpu_c_o    = req_c_i;

  always_comb begin
    is_core = 1'b0;
    is_fma  = 1'b0;
    is_ds   = 1'b0;
    case (req_op_i)
      CMD_ADD, CMD_SUB, CMD_MUL, CMD_I2F, CMD_F2I:        is_core = 1'b1;
      CMD_FMADD, CMD_FMSUB, CMD_FNMADD, CMD_FNMSUB:       is_fma  = 1'b1;
      CMD_DIV, CMD_SQRT:                                  is_ds   = 1'b1;
      default: ;
    endcase
  end

  assign known = is_core | is_fma | is_ds;

  // An issue with latency L lands in entry L-1 after this cycle's shift, so it
  // collides with what currently sits in entry L. The extra top bit is always
  // free, which is the position the longest latency checks.
  assign busy_vec = {1'b0, due_v_q};

  always_comb begin
    req_ready_o = 1'b0;
    if (rst_ni && (state_q == S_IDLE)) begin
      if (is_ds)        req_ready_o = ~|due_v_q & ~divsqrt_busy_i;
      else if (is_fma)  req_ready_o = ~busy_vec[LAT_FMA];
      else if (is_core) req_ready_o = ~busy_vec[LAT_CORE];
      else              req_ready_o = ~busy_vec[1];
    end
  end

  assign accept   = req_valid_i & req_ready_o;
  assign fpu_en_o = accept & known;

  always_comb begin
    ins_oh = '0;
    if (accept && !is_ds) begin
      if (is_fma)       ins_oh = LAT_FMA'(1) << (LAT_FMA - 1);
      else if (is_core) ins_oh = LAT_FMA'(1) << (LAT_CORE - 1);
      else              ins_oh = LAT_FMA'(1);
    end
  end

  always_comb begin
    due_v_d   = (due_v_q >> 1) | ins_oh;
    due_ill_d = (due_ill_q >> 1) | (known ? '0 : ins_oh);
    for (int unsigned i = 0; i < LAT_FMA; i++) begin
      if (i + 1 < LAT_FMA) due_tag_d[i] = due_tag_q[i+1];
      else                 due_tag_d[i] = '0;
      if (ins_oh[i])       due_tag_d[i] = req_tag_i;
    end

    state_d     = state_q;
    ds_tag_d    = ds_tag_q;
    wb_valid_d  = 1'b0;
    wb_tag_d    = '0;
    wb_result_d = '0;
    wb_flags_d  = '0;
    err_d       = err_q;

    if (accept && is_ds) begin
      state_d  = S_DIVSQRT;
      ds_tag_d = req_tag_i;
    end

    if (due_v_q[0] && due_ill_q[0]) begin
      wb_valid_d = 1'b1;
      wb_tag_d   = due_tag_q[0];
      wb_flags_d = FLAG_NV;
      if (fpu_valid_i) err_d = 1'b1;
    end else if (due_v_q[0]) begin
      if (fpu_valid_i) begin
        wb_valid_d  = 1'b1;
        wb_tag_d    = due_tag_q[0];
        wb_result_d = fpu_result_i;
        wb_flags_d  = fpu_flags_i;
      end else begin
        err_d = 1'b1;
      end
    end else if (state_q == S_DIVSQRT) begin
      if (fpu_valid_i) begin
        wb_valid_d  = 1'b1;
        wb_tag_d    = ds_tag_q;
        wb_result_d = fpu_result_i;
        wb_flags_d  = fpu_flags_i;
        state_d     = S_IDLE;
      end
    end else if (fpu_valid_i) begin
      err_d = 1'b1;
    end

    // A same-cycle clear must not drop the flags being written back now.
    fflags_d = (fflags_clr_i ? '0 : fflags_q) | (wb_valid_q ? wb_flags_q : '0);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      due_v_q     <= '0;
      due_ill_q   <= '0;
      for (int unsigned i = 0; i < LAT_FMA; i++) due_tag_q[i] <= '0;
      ds_tag_q    <= '0;
      wb_valid_q  <= 1'b0;
      wb_tag_q    <= '0;
      wb_result_q <= '0;
      wb_flags_q  <= '0;
      fflags_q    <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      due_v_q     <= due_v_d;
      due_ill_q   <= due_ill_d;
      for (int unsigned i = 0; i < LAT_FMA; i++) due_tag_q[i] <= due_tag_d[i];
      ds_tag_q    <= ds_tag_d;
      wb_valid_q  <= wb_valid_d;
      wb_tag_q    <= wb_tag_d;
      wb_result_q <= wb_result_d;
      wb_flags_q  <= wb_flags_d;
      fflags_q    <= fflags_d;
      err_q       <= err_d;
    end
  end

  assign wb_valid_o  = wb_valid_q;
  assign wb_tag_o    = wb_tag_q;
  assign wb_result_o = wb_result_q;
  assign wb_flags_o  = wb_flags_q;
  assign fflags_o    = fflags_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Testbench for fpu_issue_ctrl: combinational vector table, directed
// multi-cycle sequences and randomized traffic checked against a
// cycle-calendar reference model with a stand-in FPU.
module tb_fpu_issue_ctrl;
  localparam int LC = 2;
  localparam int LF = 3;
  localparam int NC = 4096;

  localparam logic [3:0] OP_ADD = 4'h0, OP_SUB = 4'h1, OP_MUL = 4'h2, OP_DIV = 4'h3;
  localparam logic [3:0] OP_I2F = 4'h4, OP_F2I = 4'h5, OP_SQRT = 4'h6, OP_NOP = 4'h7;
  localparam logic [3:0] OP_FMADD = 4'h8, OP_FMSUB = 4'h9, OP_FNMADD = 4'hA, OP_FNMSUB = 4'hB;
  localparam logic [3:0] OP_BAD = 4'hF;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        req_valid = 1'b0, req_ready;
  logic [3:0]  req_op = '0;
  logic [2:0]  req_rm = '0;
  logic [4:0]  req_prec = '0;
  logic [31:0] req_a = '0, req_b = '0, req_c = '0;
  logic [4:0]  req_tag = '0;
  logic        fpu_en;
  logic [3:0]  fpu_op;
  logic [2:0]  fpu_rm;
  logic [4:0]  fpu_prec;
  logic [31:0] fpu_a, fpu_b, fpu_c;
  logic        fpu_valid = 1'b0;
  logic [31:0] fpu_result = '0;
  logic [4:0]  fpu_flags = '0;
  logic        ds_busy = 1'b0;
  logic        wb_valid;
  logic [4:0]  wb_tag;
  logic [31:0] wb_result;
  logic [4:0]  wb_flags;
  logic        fflags_clr = 1'b0;
  logic [4:0]  fflags;
  logic        err;

  always #5 clk = ~clk;

  fpu_issue_ctrl #(.C_OP(32), .C_CMD(4), .C_RM(3), .C_PC(5), .C_FFLAG(5),
                   .TAG_W(5), .LAT_CORE(LC), .LAT_FMA(LF)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_op_i(req_op),
    .req_rm_i(req_rm), .req_prec_i(req_prec), .req_a_i(req_a), .req_b_i(req_b),
    .req_c_i(req_c), .req_tag_i(req_tag),
    .fpu_en_o(fpu_en), .fpu_op_o(fpu_op), .fpu_rm_o(fpu_rm), .fpu_prec_o(fpu_prec),
    .fpu_a_o(fpu_a), .fpu_b_o(fpu_b), .fpu_c_o(fpu_c),
    .fpu_valid_i(fpu_valid), .fpu_result_i(fpu_result), .fpu_flags_i(fpu_flags),
    .divsqrt_busy_i(ds_busy),
    .wb_valid_o(wb_valid), .wb_tag_o(wb_tag), .wb_result_o(wb_result), .wb_flags_o(wb_flags),
    .fflags_clr_i(fflags_clr), .fflags_o(fflags), .err_o(err)
  );

  int n_cmp = 0, n_bad = 0, cyc = 0, div_end = -1;

  // Reference calendar indexed by cycle number.
  bit          occ [NC];
  bit          fv  [NC];
  logic [31:0] fres[NC];
  logic [4:0]  fflg[NC];
  bit          ev  [NC];
  logic [4:0]  etag[NC];
  logic [31:0] eres[NC];
  logic [4:0]  eflg[NC];
  logic [4:0]  fl_m;
  bit          err_m;

  bit          obs_v[NC], obs_rdy[NC], obs_en[NC], obs_err[NC];
  logic [31:0] obs_res[NC];
  logic [4:0]  obs_tag[NC], obs_ff[NC];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  // Result latency of a command: 0 marks iterative div/sqrt, 1 an unknown op.
  function automatic int lat_of(input logic [3:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_MUL, OP_I2F, OP_F2I:     return LC;
      OP_FMADD, OP_FMSUB, OP_FNMADD, OP_FNMSUB:   return LF;
      OP_DIV, OP_SQRT:                            return 0;
      default:                                    return 1;
    endcase
  endfunction

  function automatic bit model_ready(input logic [3:0] op, input bit busy);
    int l;
    if (cyc <= div_end) return 1'b0;
    l = lat_of(op);
    if (l == 0) begin
      if (busy) return 1'b0;
      for (int k = 0; k <= LF; k++) if (occ[cyc+k]) return 1'b0;
      return 1'b1;
    end
    return !occ[cyc+l];
  endfunction

  // Stand-in FPU: exact answers for the directed operands, a hash otherwise.
  function automatic logic [31:0] fpu_fn(input logic [3:0] op, input logic [31:0] a,
                                         input logic [31:0] b, input logic [31:0] c);
    if (op == OP_ADD && a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
    if (op == OP_DIV && a == 32'h40C00000 && b == 32'h40400000) return 32'h40000000;
    return a ^ {b[15:0], b[31:16]} ^ {c[30:0], c[31]} ^ {28'h0, op};
  endfunction

  task automatic clear_model();
    for (int i = 0; i < NC; i++) begin
      occ[i] = 0; fv[i] = 0; ev[i] = 0; fres[i] = '0; fflg[i] = '0;
      etag[i] = '0; eres[i] = '0; eflg[i] = '0;
    end
    div_end = -1; fl_m = '0; err_m = 0; cyc = 0;
  endtask

  task automatic step(input bit v, input logic [3:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] c, input logic [4:0] tag,
                      input bit busy, input bit clr, input bit spur, output bit acc);
    bit rdy;
    int l, d;
    logic [4:0] f;
    @(negedge clk);
    if (cyc + 16 >= NC) begin
      $display("FAIL calendar_overflow cyc=%0d actual=%0d required=<%0d", cyc, cyc, NC - 16);
      $fatal(1);
    end
    obs_v[cyc] = wb_valid; obs_res[cyc] = wb_result; obs_tag[cyc] = wb_tag;
    obs_ff[cyc] = fflags; obs_err[cyc] = err;
    chk("wb_valid", wb_valid, ev[cyc]);
    if (ev[cyc]) begin
      chk("wb_tag", wb_tag, etag[cyc]);
      chk("wb_result", wb_result, eres[cyc]);
      chk("wb_flags", wb_flags, eflg[cyc]);
    end
    chk("fflags", fflags, fl_m);
    chk("err", err, err_m);
    req_valid = v; req_op = op; req_a = a; req_b = b; req_c = c; req_tag = tag;
    req_rm = 3'($urandom); req_prec = 5'($urandom);
    ds_busy = busy; fflags_clr = clr;
    fpu_valid = fv[cyc] | spur; fpu_result = fres[cyc]; fpu_flags = fflg[cyc];
    #1;
    rdy = model_ready(op, busy);
    obs_rdy[cyc] = req_ready; obs_en[cyc] = fpu_en;
    chk("ready", req_ready, rdy);
    acc = v && rdy;
    chk("fpu_en", fpu_en, acc && (lat_of(op) != 1));
    if (acc) begin
      l = lat_of(op);
      f = 5'($urandom);
      if (l == 1) begin
        occ[cyc+1] = 1; ev[cyc+2] = 1; etag[cyc+2] = tag; eres[cyc+2] = '0; eflg[cyc+2] = 5'b10000;
      end else begin
        d = (l == 0) ? cyc + $urandom_range(3, 8) : cyc + l;
        if (l == 0) div_end = d; else occ[d] = 1;
        fv[d] = 1; fres[d] = fpu_fn(op, a, b, c); fflg[d] = f;
        ev[d+1] = 1; etag[d+1] = tag; eres[d+1] = fres[d]; eflg[d+1] = f;
      end
    end
    if (spur) err_m = 1;
    fl_m = (clr ? 5'b0 : fl_m) | (ev[cyc] ? eflg[cyc] : 5'b0);
    cyc++;
  endtask

  task automatic idle(input int n);
    bit a;
    for (int i = 0; i < n; i++) step(0, OP_NOP, '0, '0, '0, '0, 0, 0, 0, a);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0; req_valid = 1; req_op = OP_ADD; fpu_valid = 0; fflags_clr = 0; ds_busy = 0;
    #1;
    chk("rst_ready", req_ready, 1'b0);
    chk("rst_fpu_en", fpu_en, 1'b0);
    chk("rst_wb_valid", wb_valid, 1'b0);
    chk("rst_wb_tag", wb_tag, 5'd0);
    chk("rst_wb_result", wb_result, 32'd0);
    chk("rst_wb_flags", wb_flags, 5'd0);
    chk("rst_fflags", fflags, 5'd0);
    chk("rst_err", err, 1'b0);
    @(negedge clk);
    req_valid = 0;
    rst_n = 1;
    clear_model();
  endtask

  typedef struct {
    bit         v;
    logic [3:0] op;
    bit         busy;
    bit         exp_rdy;
    bit         exp_en;
  } vec_t;

  vec_t vecs[12];

  initial begin
    bit a1;
    int t, tdiv, tk, stalls, npulse;
    logic [3:0] ops[14];

    vecs[0]  = '{1, OP_ADD,    0, 1, 1};
    vecs[1]  = '{1, OP_FMADD,  0, 1, 1};
    vecs[2]  = '{1, OP_DIV,    0, 1, 1};
    vecs[3]  = '{1, OP_DIV,    1, 0, 0};
    vecs[4]  = '{1, OP_SQRT,   1, 0, 0};
    vecs[5]  = '{1, OP_F2I,    1, 1, 1};
    vecs[6]  = '{0, OP_MUL,    0, 1, 0};
    vecs[7]  = '{1, OP_BAD,    0, 1, 0};
    vecs[8]  = '{1, OP_NOP,    0, 1, 0};
    vecs[9]  = '{1, OP_FNMSUB, 1, 1, 1};
    vecs[10] = '{0, OP_SQRT,   0, 1, 0};
    vecs[11] = '{1, OP_SUB,    0, 1, 1};

    clear_model();
    do_reset();

    // Combinational decode from the empty idle state; valid drops before the edge.
    foreach (vecs[i]) begin
      @(negedge clk);
      req_valid = vecs[i].v; req_op = vecs[i].op; ds_busy = vecs[i].busy;
      req_a = $urandom; req_b = $urandom; req_c = $urandom;
      req_rm = 3'($urandom); req_prec = 5'($urandom);
      #1;
      chk("vec_ready", req_ready, vecs[i].exp_rdy);
      chk("vec_en", fpu_en, vecs[i].exp_en);
      chk("vec_pass", {fpu_op, fpu_rm, fpu_prec}, {req_op, req_rm, req_prec});
      chk("vec_pass_ab", {fpu_a, fpu_b}, {req_a, req_b});
      chk("vec_pass_c", fpu_c, req_c);
      req_valid = 0; ds_busy = 0;
    end

    // Single ADD: result LAT_CORE+1 cycles after issue.
    t = cyc;
    step(1, OP_ADD, 32'h3F800000, 32'h40000000, '0, 5'd3, 0, 0, 0, a1);
    idle(5);
    chk("add_en", obs_en[t], 1'b1);
    chk("add_en_once", obs_en[t+1], 1'b0);
    chk("add_wb_early", obs_v[t+LC], 1'b0);
    chk("add_wb_valid", obs_v[t+LC+1], 1'b1);
    chk("add_wb_result", obs_res[t+LC+1], 32'h40400000);
    chk("add_wb_tag", obs_tag[t+LC+1], 5'd3);

    // ADD then FMADD back-to-back: both accepted, ADD writes back first.
    t = cyc;
    step(1, OP_ADD, 32'h11111111, 32'h22222222, '0, 5'd4, 0, 0, 0, a1);
    step(1, OP_FMADD, 32'h33333333, 32'h44444444, 32'h55555555, 5'd5, 0, 0, 0, a1);
    idle(6);
    chk("b2b_rdy0", obs_rdy[t], 1'b1);
    chk("b2b_rdy1", obs_rdy[t+1], 1'b1);
    chk("b2b_add_tag", {obs_v[t+LC+1], obs_tag[t+LC+1]}, {1'b1, 5'd4});
    chk("b2b_gap", obs_v[t+LC+2], 1'b0);
    chk("b2b_fma_tag", {obs_v[t+1+LF+1], obs_tag[t+1+LF+1]}, {1'b1, 5'd5});

    // ADD LAT_FMA-LAT_CORE cycles after FMADD clashes for the writeback slot.
    t = cyc;
    step(1, OP_FMADD, 32'h1, 32'h2, 32'h3, 5'd6, 0, 0, 0, a1);
    step(1, OP_ADD, 32'h4, 32'h5, '0, 5'd7, 0, 0, 0, a1);
    step(1, OP_ADD, 32'h4, 32'h5, '0, 5'd7, 0, 0, 0, a1);
    idle(6);
    chk("clash_rdy", obs_rdy[t+LF-LC], 1'b0);
    chk("clash_next_rdy", obs_rdy[t+LF-LC+1], 1'b1);

    // DIV behind an in-flight ADD stalls until the slots drain, then blocks issue.
    t = cyc;
    step(1, OP_ADD, 32'h6, 32'h7, '0, 5'd8, 0, 0, 0, a1);
    a1 = 0; stalls = 0;
    while (!a1 && stalls < 20) begin
      step(1, OP_DIV, 32'h40C00000, 32'h40400000, '0, 5'd10, 0, 0, 0, a1);
      stalls++;
    end
    tdiv = cyc - 1;
    chk("div_accept_cycle", tdiv - t, LC + 1);
    a1 = 0; stalls = 0;
    while (!a1 && stalls < 30) begin
      step(1, OP_ADD, 32'h8, 32'h9, '0, 5'd11, 0, 0, 0, a1);
      stalls++;
    end
    tk = cyc - 1;
    chk("div_done_bound", a1, 1'b1);
    chk("div_blocked", obs_rdy[tk-1], 1'b0);
    chk("div_wb", {obs_v[tk], obs_tag[tk]}, {1'b1, 5'd10});
    chk("div_result", obs_res[tk], 32'h40000000);
    npulse = 0;
    for (int i = t + 1; i < tk; i++) npulse += int'(obs_en[i]);
    chk("div_one_pulse", npulse, 1);
    idle(5);

    // Unknown command: NV writeback, sticky flag, then clear.
    t = cyc;
    step(1, OP_BAD, 32'hDEADBEEF, 32'h1, 32'h2, 5'd9, 0, 0, 0, a1);
    idle(3);
    chk("bad_wb", {obs_v[t+2], obs_tag[t+2]}, {1'b1, 5'd9});
    chk("bad_result", obs_res[t+2], 32'd0);
    chk("bad_nv", obs_ff[t+3][4], 1'b1);
    step(0, OP_NOP, '0, '0, '0, '0, 0, 1, 0, a1);
    idle(1);
    chk("clr_fflags", obs_ff[t+5], 5'd0);

    // Clear in the same cycle as a writeback keeps the new flags.
    t = cyc;
    step(1, OP_BAD, '0, '0, '0, 5'd2, 0, 0, 0, a1);
    idle(1);
    step(0, OP_NOP, '0, '0, '0, '0, 0, 1, 0, a1);
    idle(1);
    chk("clr_wb_same", obs_ff[t+3], 5'b10000);

    // Spurious fpu_valid in idle sets a sticky error.
    idle(3);
    t = cyc;
    step(0, OP_NOP, '0, '0, '0, '0, 0, 0, 1, a1);
    idle(3);
    chk("spur_before", obs_err[t], 1'b0);
    chk("spur_err", obs_err[t+1], 1'b1);
    chk("spur_sticky", obs_err[t+3], 1'b1);

    // Reset in the middle of a DIV.
    a1 = 0; stalls = 0;
    while (!a1 && stalls < 20) begin
      step(1, OP_DIV, 32'h40C00000, 32'h40400000, '0, 5'd12, 0, 0, 0, a1);
      stalls++;
    end
    chk("div2_accept", a1, 1'b1);
    idle(1);
    do_reset();
    t = cyc;
    step(1, OP_ADD, 32'h3F800000, 32'h40000000, '0, 5'd13, 0, 0, 0, a1);
    idle(5);
    chk("post_rst_ready", obs_rdy[t], 1'b1);

    // Randomized traffic against the calendar model.
    ops = '{OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_I2F, OP_F2I, OP_SQRT, OP_FMADD,
            OP_FMSUB, OP_FNMADD, OP_FNMSUB, OP_NOP, OP_BAD, 4'hC};
    for (int i = 0; i < 1500; i++) begin
      step(($urandom % 4) != 0, ops[$urandom_range(0, 13)], $urandom, $urandom, $urandom,
           5'($urandom), ($urandom % 5) == 0, ($urandom % 16) == 0, 0, a1);
    end
    idle(12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
